// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle for the hazard/forwarding unit: instruction fields and
// pipeline controls in, stall and bypass selects out.
interface hazard_fwd_unit_if #(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned NPORTS = 3,
    parameter int unsigned CNT_W  = 16
);
    logic                    id_valid;
    logic [NPORTS*REG_W-1:0] id_rs;
    logic [NPORTS-1:0]       id_re;
    logic [REG_W-1:0]        id_rd;
    logic                    id_we;
    logic                    id_load;
    logic                    hold;
    logic                    flush;
    logic                    stall;
    logic [NPORTS*2-1:0]     fwd_sel;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output id_valid, id_rs, id_re, id_rd, id_we, id_load, hold, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_re, id_rd, id_we, id_load, hold, flush,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Tracks in-flight destinations in EX/MEM/WB/retire slots, stalls decode on
// load-use hazards and registers per-port bypass selects for the EX stage.
module hazard_fwd_unit #(
    parameter int unsigned REG_W    = 4,
    parameter int unsigned NPORTS   = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_unit_if.slave bus
);
    localparam logic RUN   = 1'b0;
    localparam logic STALL = 1'b1;
    localparam int unsigned NSLOT = 4;

    logic [REG_W-1:0]    rd_q [NSLOT];
    logic [REG_W-1:0]    rd_d [NSLOT];
    logic [NSLOT-1:0]    we_q, we_d;
    logic [NSLOT-1:0]    ld_q, ld_d;
    logic [NPORTS*2-1:0] fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                state_q, state_d;

    logic                hazard;
    logic                stall;
    logic                accept;
    logic [NSLOT-1:0]    match [NPORTS];

    always_comb begin
        hazard = 1'b0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                match[p][k] = bus.id_re[p] && we_q[k] &&
                              (bus.id_rs[p*REG_W +: REG_W] == rd_q[k]);
                if (match[p][k] && ld_q[k] && (k < LOAD_LAT)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall       = bus.id_valid && hazard && !bus.flush;
        accept      = bus.id_valid && !stall && !bus.hold && !bus.flush;
        rd_d        = rd_q;
        we_d        = we_q;
        ld_d        = ld_q;
        fwd_sel_d   = fwd_sel_q;
        stall_cnt_d = stall_cnt_q;
        state_d     = state_q;

        if (!bus.hold) begin
            for (int unsigned k = 1; k < NSLOT; k++) begin
                rd_d[k] = rd_q[k-1];
                we_d[k] = we_q[k-1];
                ld_d[k] = ld_q[k-1];
            end
            // A flushed EX instruction never reaches MEM.
            if (bus.flush) begin
                rd_d[1] = '0;
                we_d[1] = 1'b0;
                ld_d[1] = 1'b0;
            end
            rd_d[0] = accept ? bus.id_rd   : '0;
            we_d[0] = accept && bus.id_we;
            ld_d[0] = accept && bus.id_load;

            // Scan oldest to youngest so the youngest producer wins.
            fwd_sel_d = '0;
            if (accept) begin
                for (int unsigned p = 0; p < NPORTS; p++) begin
                    for (int unsigned j = 0; j < NSLOT-1; j++) begin
                        if (match[p][NSLOT-2-j]) begin
                            fwd_sel_d[p*2 +: 2] = 2'(NSLOT-1-j);
                        end
                    end
                end
            end

            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end

            case (state_q)
                RUN:     if (stall)  state_d = STALL;
                STALL:   if (!stall) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                rd_q[k] <= '0;
            end
            we_q        <= '0;
            ld_q        <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
            state_q     <= RUN;
        end else begin
            rd_q        <= rd_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
            state_q     <= state_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.fwd_sel   = fwd_sel_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Drives three configurations (LOAD_LAT=1, LOAD_LAT=2, CNT_W=2) with shared
// stimulus and compares each against a producer-history reference model.
module tb_hazard_fwd_unit;
    logic clk;
    logic rst;

    logic        s_valid;
    logic [11:0] s_rs;
    logic [2:0]  s_re;
    logic [3:0]  s_rd;
    logic        s_we;
    logic        s_ld;
    logic        s_hold;
    logic        s_flush;

    hazard_fwd_unit_if #(.REG_W(4), .NPORTS(3), .CNT_W(16)) if_a ();
    hazard_fwd_unit_if #(.REG_W(4), .NPORTS(3), .CNT_W(16)) if_b ();
    hazard_fwd_unit_if #(.REG_W(4), .NPORTS(3), .CNT_W(2))  if_c ();

    hazard_fwd_unit #(.REG_W(4), .NPORTS(3), .LOAD_LAT(1), .CNT_W(16))
        u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    hazard_fwd_unit #(.REG_W(4), .NPORTS(3), .LOAD_LAT(2), .CNT_W(16))
        u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    hazard_fwd_unit #(.REG_W(4), .NPORTS(3), .LOAD_LAT(1), .CNT_W(2))
        u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.id_valid = s_valid; assign if_b.id_valid = s_valid; assign if_c.id_valid = s_valid;
    assign if_a.id_rs    = s_rs;    assign if_b.id_rs    = s_rs;    assign if_c.id_rs    = s_rs;
    assign if_a.id_re    = s_re;    assign if_b.id_re    = s_re;    assign if_c.id_re    = s_re;
    assign if_a.id_rd    = s_rd;    assign if_b.id_rd    = s_rd;    assign if_c.id_rd    = s_rd;
    assign if_a.id_we    = s_we;    assign if_b.id_we    = s_we;    assign if_c.id_we    = s_we;
    assign if_a.id_load  = s_ld;    assign if_b.id_load  = s_ld;    assign if_c.id_load  = s_ld;
    assign if_a.hold     = s_hold;  assign if_b.hold     = s_hold;  assign if_c.hold     = s_hold;
    assign if_a.flush    = s_flush; assign if_b.flush    = s_flush; assign if_c.flush    = s_flush;

    logic [2:0] o_stall;
    logic [5:0] o_fwd [3];
    int         o_cnt [3];
    assign o_stall  = {if_c.stall, if_b.stall, if_a.stall};
    assign o_fwd[0] = if_a.fwd_sel;
    assign o_fwd[1] = if_b.fwd_sel;
    assign o_fwd[2] = if_c.fwd_sel;
    assign o_cnt[0] = int'(if_a.stall_cnt);
    assign o_cnt[1] = int'(if_b.stall_cnt);
    assign o_cnt[2] = int'(if_c.stall_cnt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each entry is an in-flight producer, index = age in slots past decode.
    typedef struct {
        int rd;
        bit we;
        bit ld;
    } prod_t;

    prod_t   hist  [3][4];
    int      m_fwd [3][3];
    int      m_cnt [3];
    int      lat   [3] = '{1, 2, 1};
    int      cmax  [3] = '{65535, 65535, 3};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic bit m_match(int i, int p, int age);
        return s_re[p] && hist[i][age].we && (hist[i][age].rd == int'(s_rs[p*4 +: 4]));
    endfunction

    function automatic bit m_stall(int i);
        bit hz = 1'b0;
        for (int p = 0; p < 3; p++)
            for (int age = 0; age < lat[i]; age++)
                if (m_match(i, p, age) && hist[i][age].ld) hz = 1'b1;
        return s_valid && hz && !s_flush;
    endfunction

    task automatic m_step(input int i, input bit st);
        bit acc;
        int code;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                hist[i][k].rd = 0; hist[i][k].we = 0; hist[i][k].ld = 0;
            end
            for (int p = 0; p < 3; p++) m_fwd[i][p] = 0;
            m_cnt[i] = 0;
            return;
        end
        if (s_hold) return;
        acc = s_valid && !st && !s_flush;
        for (int p = 0; p < 3; p++) begin
            code = 0;
            if (acc)
                for (int age = 2; age >= 0; age--)
                    if (m_match(i, p, age)) code = age + 1;
            m_fwd[i][p] = code;
        end
        if (st && m_cnt[i] < cmax[i]) m_cnt[i]++;
        hist[i][3] = hist[i][2];
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        if (s_flush) begin
            hist[i][1].rd = 0; hist[i][1].we = 0; hist[i][1].ld = 0;
        end
        if (acc) begin
            hist[i][0].rd = int'(s_rd); hist[i][0].we = s_we; hist[i][0].ld = s_ld;
        end else begin
            hist[i][0].rd = 0; hist[i][0].we = 0; hist[i][0].ld = 0;
        end
    endtask

    task automatic cycle();
        bit es [3];
        #1;
        for (int i = 0; i < 3; i++) begin
            es[i] = m_stall(i);
            check($sformatf("stall[%0d]", i), int'(o_stall[i]), int'(es[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) m_step(i, es[i]);
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 3; p++)
                check($sformatf("fwd[%0d].p%0d", i, p), int'(o_fwd[i][p*2 +: 2]), m_fwd[i][p]);
            check($sformatf("cnt[%0d]", i), o_cnt[i], m_cnt[i]);
        end
    endtask

    task automatic drive(input bit v, input int rs0, input int rs1, input int rs2,
                         input logic [2:0] re, input int rd, input bit we, input bit ld);
        s_valid = v;
        s_rs    = {4'(rs2), 4'(rs1), 4'(rs0)};
        s_re    = re;
        s_rd    = 4'(rd);
        s_we    = we;
        s_ld    = ld;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; s_hold = 1'b0; s_flush = 1'b0;
        idle();
        cycle();
        rst = 1'b0;
    endtask

    int gap_exp [4] = '{1, 2, 3, 0};

    initial begin
        rst = 1'b1; s_hold = 1'b0; s_flush = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            for (int p = 0; p < 3; p++) m_fwd[i][p] = 0;
            for (int k = 0; k < 4; k++) begin
                hist[i][k].rd = 0; hist[i][k].we = 0; hist[i][k].ld = 0;
            end
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_fwd[%0d]", i), int'(o_fwd[i]), 0);
            check($sformatf("rst_cnt[%0d]", i), o_cnt[i], 0);
            check($sformatf("rst_stall[%0d]", i), int'(o_stall[i]), 0);
        end

        // ALU producer R1, consumer after 0..3 NOPs
        for (int gap = 0; gap < 4; gap++) begin
            do_reset();
            drive(1, 0, 0, 0, 3'b000, 1, 1, 0); cycle();
            repeat (gap) begin idle(); cycle(); end
            drive(1, 1, 3, 0, 3'b011, 2, 1, 0); cycle();
            check($sformatf("alu_gap%0d", gap), int'(o_fwd[0][1:0]), gap_exp[gap]);
        end

        // Load-use on the store-data port
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 4, 1, 1); cycle();
        drive(1, 0, 0, 4, 3'b100, 0, 0, 0); cycle();
        check("ldu_cnt_l1_a", o_cnt[0], 1);
        check("ldu_cnt_l2_a", o_cnt[1], 1);
        check("ldu_stall_l1", int'(o_stall[0]), 0);
        check("ldu_stall_l2", int'(o_stall[1]), 1);
        cycle();
        check("ldu_fwd_l1", int'(o_fwd[0][5:4]), 2);
        check("ldu_cnt_l1_b", o_cnt[0], 1);
        check("ldu_cnt_l2_b", o_cnt[1], 2);
        cycle();
        check("ldu_fwd_l2", int'(o_fwd[1][5:4]), 3);
        check("ldu_cnt_l2_c", o_cnt[1], 2);

        // Load-use stall frozen by hold
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 4, 1, 1); cycle();
        drive(1, 0, 0, 4, 3'b100, 0, 0, 0);
        s_hold = 1'b1;
        repeat (3) cycle();
        check("hold_cnt", o_cnt[0], 0);
        check("hold_fwd", int'(o_fwd[0]), 0);
        check("hold_stall", int'(o_stall[0]), 1);
        s_hold = 1'b0;
        cycle();
        check("hold_cnt_after", o_cnt[0], 1);
        cycle();
        check("hold_fwd_after", int'(o_fwd[0][5:4]), 2);

        // Two producers of R5, youngest wins on both ALU ports
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 5, 1, 0); cycle(); cycle();
        drive(1, 5, 5, 0, 3'b011, 6, 1, 0); cycle();
        check("youngest_fwd", int'(o_fwd[0]), 6'b000101);

        // Flush discards the EX producer
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 6, 1, 0); cycle();
        drive(1, 6, 0, 0, 3'b001, 7, 1, 0);
        s_flush = 1'b1; cycle();
        s_flush = 1'b0; cycle();
        check("flush_fwd", int'(o_fwd[0][1:0]), 0);

        // Counter saturation on the narrow-counter instance, then reset mid-stall
        do_reset();
        repeat (5) begin
            drive(1, 0, 0, 0, 3'b000, 4, 1, 1); cycle();
            drive(1, 0, 0, 4, 3'b100, 0, 0, 0); cycle(); cycle();
        end
        check("sat_cnt_c", o_cnt[2], 3);
        check("sat_cnt_a", o_cnt[0], 5);
        drive(1, 0, 0, 0, 3'b000, 4, 1, 1); cycle();
        drive(1, 0, 0, 4, 3'b100, 0, 0, 0);
        #1 check("mid_stall", int'(o_stall[2]), 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("mid_rst_cnt", o_cnt[2], 0);
        check("mid_rst_fwd", int'(o_fwd[2]), 0);
        #1 check("mid_rst_stall", int'(o_stall[2]), 0);

        // Random traffic over a small register set to provoke frequent hazards
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 99) < 2);
            s_hold  = ($urandom_range(0, 99) < 10);
            s_flush = ($urandom_range(0, 99) < 8);
            drive($urandom_range(0, 99) < 80,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 30);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
